// File: rtl/board_io_conditioner.sv
// Board pin front end: synchronises, debounces and edge-detects the switches and
// buttons, and derives a stretched CPU reset from one debounced button.
module board_io_conditioner #(
  parameter int NUM_SW          = 16,
  parameter int NUM_BTN         = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int RESET_BTN       = 0,
  parameter int RESET_STRETCH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bypass,
  input  logic [NUM_SW-1:0]  sw_in,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_SW-1:0]  sw_out,
  output logic [NUM_BTN-1:0] btn_out,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               sw_changed,
  output logic               sys_reset
);

  localparam int N       = NUM_SW + NUM_BTN;
  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int STR_W   = $clog2(RESET_STRETCH + 1);
  localparam int RST_BIT = NUM_SW + RESET_BTN;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STR_W-1:0] STR_LOAD = STR_W'(RESET_STRETCH);

  function automatic logic [STR_W-1:0] sat_dec(input logic [STR_W-1:0] v);
    return (v == '0) ? '0 : v - STR_W'(1);
  endfunction

  logic [N-1:0]     pins;
  logic [N-1:0]     sync_p0 [SYNC_STAGES];
  logic [N-1:0]     seen;
  logic [CNT_W-1:0] cnt_p1 [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [N-1:0]     stable_p1;
  logic [N-1:0]     stable_d;
  logic [STR_W-1:0] str_p2;
  logic [STR_W-1:0] str_d;

  // Switches occupy the low bits, buttons the high bits of one shared vector.
  assign pins = {btn_in, sw_in};
  assign seen = sync_p0[SYNC_STAGES-1];

  // Stage p1: per-bit debounce; a new level needs DEBOUNCE_CYCLES differing edges.
  always_comb begin
    stable_d = stable_p1;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (bypass) begin
        stable_d[i] = seen[i];
      end else if (seen[i] != stable_p1[i]) begin
        if (cnt_p1[i] == CNT_LAST) stable_d[i] = seen[i];
        else cnt_d[i] = cnt_p1[i] + CNT_W'(1);
      end
    end
  end

  // Stage p2: reset stretch reloads while the registered reset button is held.
  assign str_d = stable_p1[RST_BIT] ? STR_LOAD : sat_dec(str_p2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p0[s] <= '0;
      for (int i = 0; i < N; i++) cnt_p1[i] <= '0;
      stable_p1   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      sw_changed  <= 1'b0;
      str_p2      <= STR_LOAD;
      sys_reset   <= 1'b1;
    end else begin
      sync_p0[0] <= pins;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p0[s] <= sync_p0[s-1];
      cnt_p1      <= cnt_d;
      stable_p1   <= stable_d;
      // Pulses come from the next stable value so they coincide with the new level.
      btn_press   <= stable_d[N-1:NUM_SW] & ~stable_p1[N-1:NUM_SW];
      btn_release <= ~stable_d[N-1:NUM_SW] & stable_p1[N-1:NUM_SW];
      sw_changed  <= |(stable_d[NUM_SW-1:0] ^ stable_p1[NUM_SW-1:0]);
      str_p2      <= str_d;
      sys_reset   <= stable_d[RST_BIT] | (str_d != '0);
    end
  end

  assign sw_out  = stable_p1[NUM_SW-1:0];
  assign btn_out = stable_p1[N-1:NUM_SW];

endmodule

// File: doc/board_io_conditioner.md
Name: board_io_conditioner

Overview:
Parametrised input front end for the Basys3 system top. It conditions the raw slide-switch and push-button pins: synchronisation, per-bit debounce, and edge-pulse generation. It also derives a stretched system reset from a selectable button. It sits between the board pins and the CPU I/O ports, replacing direct pin-to-port wiring. A bypass mode gives fast simulation without long debounce times.

Parameters:
NUM_SW, 16, number of switch inputs
NUM_BTN, 5, number of button inputs
SYNC_STAGES, 2, flip-flops per synchroniser chain (min 2)
DEBOUNCE_CYCLES, 65536, consecutive differing cycles required to accept a new level (min 2)
RESET_BTN, 0, index of the button that generates sys_reset
RESET_STRETCH, 4, cycles sys_reset stays high after the reset condition clears (min 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
bypass  input  1  1 = skip debounce (stable follows synchronised value); must be static during operation
sw_in  input  NUM_SW  raw switch pins
btn_in  input  NUM_BTN  raw button pins, active-high
sw_out  output  NUM_SW  debounced switch levels
btn_out  output  NUM_BTN  debounced button levels
btn_press  output  NUM_BTN  one-cycle pulse on debounced 0->1
btn_release  output  NUM_BTN  one-cycle pulse on debounced 1->0
sw_changed  output  1  one-cycle pulse when any debounced switch bit changes
sys_reset  output  1  active-high stretched reset to the CPU core

Behaviour:
- Reset (rst_n=0, async): all sync flops, stable levels, counters and pulses go to 0; sys_reset=1 immediately; stretch counter loads RESET_STRETCH.
- Synchroniser: per bit, SYNC_STAGES flops. The last stage reflects a pin change after SYNC_STAGES rising edges.
- Debounce (bypass=0), per bit, counter width clog2(DEBOUNCE_CYCLES):
  - Edge with sync==stable: counter <= 0.
  - Edge with sync!=stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - Edge with sync!=stable and counter == DEBOUNCE_CYCLES-1: stable <= sync; counter <= 0.
  - Any equal cycle restarts the count. Glitches shorter than DEBOUNCE_CYCLES never propagate.
  - Total latency from a clean pin change: SYNC_STAGES + DEBOUNCE_CYCLES edges.
- Bypass (bypass=1): stable <= sync every edge; counters held at 0; latency SYNC_STAGES+1 edges.
- Outputs: sw_out and btn_out are the stable registers.
- Pulses are registered. They are high for exactly the one cycle in which the new stable value first appears.
  - btn_press[i] = rising transition of stable button i; btn_release[i] = falling transition.
  - sw_changed = OR over all switch bits of a stable transition. Multiple bits changing on the same edge give a single one-cycle pulse.
  - A continuously held input never repeats a pulse.
- sys_reset:
  - While btn_out[RESET_BTN]=1: sys_reset=1 and the stretch counter reloads to RESET_STRETCH.
  - Once btn_out[RESET_BTN]=0 (including immediately after rst_n release), the counter decrements each edge. sys_reset deasserts on the edge where the counter reaches 0, so it stays high exactly RESET_STRETCH cycles.
  - A re-press during stretch reloads the counter.
  - The reset button still produces press/release pulses.
- Simultaneous events: all bits are independent. Press on one button and release on another in the same cycle both pulse.
- rst_n asserted mid-debounce: progress is discarded; outputs return to reset values without waiting for a clock.

Test Plan:
- Reset stretch (SYNC=2, DEB=4, STRETCH=3, bypass=0, all inputs 0): release rst_n -> sys_reset=1 for exactly 3 edges, then 0; all other outputs 0.
- Clean press: btn_in[1] 0->1 held -> btn_out[1]=1 exactly 6 edges later; btn_press[1]=1 for that single cycle only.
- Glitch rejection: btn_in[2] high for 3 cycles then low -> btn_out[2] stays 0, no pulse. Held high for 4+ sync-aligned cycles -> accepted.
- Switch bank: sw_in 0x0000->0xdbaa simultaneously -> sw_out=0xdbaa after 6 edges; sw_changed pulses once. sw_in then returns to 0x0000 -> sw_out=0x0000 after 6 edges; one more single-cycle pulse.
- Bypass=1: btn_in[0] high for 2 cycles -> btn_out[0] high 2 cycles, starting 3 edges after the input rose; sys_reset stays high while btn_out[0]=1 plus 3 cycles.
- Mid-operation reset: assert rst_n low 2 edges into a debounce count -> outputs clear asynchronously and sys_reset=1. After release, the input must complete the full 6-edge latency again.
